bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 145 ++++++++++++++
 tb/tb_bullet_pool.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of projectile slots with spawn, move, hit and clear.
// Optional refire lockout is enabled with `define BULLET_POOL_COOLDOWN_EN.
module bullet_pool #(
  parameter int NUM_BULLETS     = 6,
  parameter int COORD_W         = 10,
  parameter int SPAWN_Y_OFFSET  = 7,
  parameter int STEP            = 1,
  parameter int MIN_Y           = 2,
  parameter int PARK_Y          = 1000,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             stop,
  input  logic                             clear,
  input  logic                             fire,
  input  logic                             move_tick,
  input  logic [COORD_W-1:0]               user_x,
  input  logic [COORD_W-1:0]               user_y,
  input  logic [NUM_BULLETS-1:0]           hit,
  output logic [NUM_BULLETS-1:0]           active,
  output logic [NUM_BULLETS*COORD_W-1:0]   bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0]   bullet_y,
  output logic [$clog2(NUM_BULLETS+1)-1:0] free_count,
  output logic                             fire_drop
);

  localparam int CNT_W = $clog2(NUM_BULLETS + 1);
  localparam int IDX_W =
    (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W =
    (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  localparam logic [COORD_W-1:0] PARK  = COORD_W'(PARK_Y);
  localparam logic [COORD_W-1:0] STP   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] OFS   = COORD_W'(SPAWN_Y_OFFSET);
  localparam logic [COORD_W-1:0] LIVE  = COORD_W'(MIN_Y + STEP);

  logic [COORD_W-1:0]     x_q [NUM_BULLETS];
  logic [COORD_W-1:0]     y_q [NUM_BULLETS];
  logic [COORD_W-1:0]     x_n [NUM_BULLETS];
  logic [COORD_W-1:0]     y_n [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] act_n;
  logic [CNT_W-1:0]       cnt_n;
  logic [IDX_W-1:0]       sel;
  logic                   fire_prev;
  logic                   fire_edge;
  logic                   try_fire;
  logic                   any_free;
  logic                   accept;
  logic                   drop_n;
  logic [CD_W-1:0]        cooldown;

`ifdef BULLET_POOL_COOLDOWN_EN
  // refire lockout: load on each spawn, count down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cooldown <= '0;
    else if (clear)
      cooldown <= '0;
    else if (accept)
      cooldown <= CD_W'(COOLDOWN_CYCLES);
    else if (cooldown != '0)
      cooldown <= cooldown - CD_W'(1);
  end
`else
  assign cooldown = '0;
`endif

  // next-state: hit beats movement, spawn uses pre-edge free slots,
  // clear overrides everything
  always_comb begin
    fire_edge = fire & ~fire_prev;
    any_free  = ~&active;
    sel       = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--)
      if (!active[i]) sel = IDX_W'(i);
    try_fire = fire_edge & ~stop & ~clear;
    accept   = try_fire & any_free & (cooldown == '0);
    drop_n   = try_fire & ~accept;
    act_n    = active;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_n[i] = x_q[i];
      y_n[i] = y_q[i];
      if (hit[i]) begin
        act_n[i] = 1'b0;
        y_n[i]   = PARK;
      end else if (move_tick && !stop && active[i]) begin
        if (y_q[i] >= LIVE) begin
          y_n[i] = y_q[i] - STP;
        end else begin
          act_n[i] = 1'b0;
          y_n[i]   = PARK;
        end
      end
    end
    if (accept) begin
      act_n[sel] = 1'b1;
      x_n[sel]   = user_x;
      y_n[sel]   = user_y - OFS;
    end
    if (clear) begin
      act_n = '0;
      for (int i = 0; i < NUM_BULLETS; i++)
        y_n[i] = PARK;
    end
    cnt_n = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      if (!act_n[i]) cnt_n = cnt_n + CNT_W'(1);
  end

  // slot state, free count and drop pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= '0;
      free_count <= CNT_W'(NUM_BULLETS);
      fire_drop  <= 1'b0;
      fire_prev  <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= PARK;
      end
    end else begin
      active     <= act_n;
      free_count <= cnt_n;
      fire_drop  <= drop_n;
      fire_prev  <= fire;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= x_n[i];
        y_q[i] <= y_n[i];
      end
    end
  end

  // pack per-slot coordinates onto the flat output buses
  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_x[i*COORD_W +: COORD_W] = x_q[i];
      bullet_y[i*COORD_W +: COORD_W] = y_q[i];
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed scoreboard bench for bullet_pool.
// Cooldown checks adapt to BULLET_POOL_COOLDOWN_EN.
module tb_bullet_pool;

`ifdef BULLET_POOL_COOLDOWN_EN
  localparam bit CD  = 1'b1;
  localparam int GAP = 8;
`else
  localparam bit CD  = 1'b0;
  localparam int GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stop, clear, fire, move_tick;
  logic [9:0]  user_x, user_y;
  logic [5:0]  hit;
  logic [5:0]  active;
  logic [59:0] bullet_x, bullet_y;
  logic [2:0]  free_count;
  logic        fire_drop;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  bullet_pool dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stop       (stop),
    .clear      (clear),
    .fire       (fire),
    .move_tick  (move_tick),
    .user_x     (user_x),
    .user_y     (user_y),
    .hit        (hit),
    .active     (active),
    .bullet_x   (bullet_x),
    .bullet_y   (bullet_y),
    .free_count (free_count),
    .fire_drop  (fire_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bx(int i);
    return 32'(bullet_x[i*10 +: 10]);
  endfunction

  function automatic logic [31:0] by(int i);
    return 32'(bullet_y[i*10 +: 10]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: observed=%0d expected=entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.v);
    end
  endtask

  initial begin
    logic [31:0] a9;
    reset_n = 1'b0;
    stop = 0; clear = 0; fire = 0; move_tick = 0;
    user_x = '0; user_y = '0; hit = '0;
    idle(2);
    push("rst_active", 0);
    push("rst_free", 6);
    push("rst_drop", 0);
    push("rst_y0", 1000);
    push("rst_x0", 0);
    push("rst_y5", 1000);
    pop_chk(active); pop_chk(free_count); pop_chk(fire_drop);
    pop_chk(by(0)); pop_chk(bx(0)); pop_chk(by(5));
    reset_n = 1'b1;
    user_x = 10'd310;
    user_y = 10'd400;
    tick();

    // first spawns
    fire = 1;
    push("s0_active", 1); push("s0_x", 310);
    push("s0_y", 393); push("s0_free", 5);
    tick();
    pop_chk(active); pop_chk(bx(0));
    pop_chk(by(0)); pop_chk(free_count);
    fire = 0;
    idle(GAP);
    fire = 1;
    push("s1_active", 3); push("s1_x", 310);
    push("s1_y", 393); push("s1_free", 4);
    tick();
    pop_chk(active); pop_chk(bx(1));
    pop_chk(by(1)); pop_chk(free_count);
    fire = 0;

    // fill the pool, seventh edge is dropped
    clear = 1;
    push("clr_active", 0); push("clr_free", 6);
    tick();
    pop_chk(active); pop_chk(free_count);
    clear = 0;
    for (int k = 0; k < 7; k++) begin
      idle(GAP);
      fire = 1;
      if (k < 6) begin
        push("fill_active", (32'd1 << (k + 1)) - 1);
        push("fill_drop", 0);
      end else begin
        push("full_active", 63);
        push("full_drop", 1);
      end
      tick();
      pop_chk(active); pop_chk(fire_drop);
      fire = 0;
    end
    push("full_free", 0); push("drop_pulse", 0);
    tick();
    pop_chk(free_count); pop_chk(fire_drop);
    idle(GAP);

    // hit frees slot 2 but the same-edge fire is dropped
    hit = 6'b000100;
    fire = 1;
    push("hit_active", 6'b111011); push("hit_y2", 1000);
    push("hit_drop", 1); push("hit_free", 1);
    tick();
    pop_chk(active); pop_chk(by(2));
    pop_chk(fire_drop); pop_chk(free_count);
    hit = '0;
    fire = 0;
    idle(GAP);
    fire = 1;
    push("re_active", 63); push("re_y2", 393); push("re_drop", 0);
    tick();
    pop_chk(active); pop_chk(by(2)); pop_chk(fire_drop);
    fire = 0;

    // movement down to MIN_Y then park
    clear = 1;
    tick();
    clear = 0;
    user_y = 10'd10;
    fire = 1;
    push("mv_y0", 3);
    tick();
    pop_chk(by(0));
    fire = 0;
    move_tick = 1;
    push("mv1_y0", 2); push("mv1_act", 1);
    tick();
    pop_chk(by(0)); pop_chk(active);
    push("mv2_y0", 1000); push("mv2_act", 0);
    tick();
    pop_chk(by(0)); pop_chk(active);
    move_tick = 0;

    // spawn on a move_tick edge is not moved
    user_y = 10'd400;
    idle(GAP);
    fire = 1;
    move_tick = 1;
    push("same_y0", 393); push("same_act", 1);
    tick();
    pop_chk(by(0)); pop_chk(active);
    fire = 0;
    move_tick = 0;

    // cooldown window: edges at cycles 0, 4, 9
    clear = 1;
    tick();
    clear = 0;
    fire = 1;
    push("cd0_act", 1);
    tick();
    pop_chk(active);
    fire = 0;
    idle(3);
    fire = 1;
    push("cd4_act", CD ? 1 : 3); push("cd4_drop", CD ? 1 : 0);
    tick();
    pop_chk(active); pop_chk(fire_drop);
    fire = 0;
    idle(4);
    a9 = CD ? 32'd3 : 32'd7;
    fire = 1;
    push("cd9_act", a9); push("cd9_drop", 0);
    tick();
    pop_chk(active); pop_chk(fire_drop);
    fire = 0;
    idle(GAP);

    // stop freezes movement and spawn, hit still works
    stop = 1;
    move_tick = 1;
    fire = 1;
    push("st_act", a9); push("st_y0", 393);
    push("st_y1", 393); push("st_drop", 0);
    tick();
    pop_chk(active); pop_chk(by(0));
    pop_chk(by(1)); pop_chk(fire_drop);
    fire = 0;
    push("st2_y1", 393);
    tick();
    pop_chk(by(1));
    hit = 6'b000001;
    push("sh_act", a9 & ~32'd1); push("sh_y0", 1000);
    tick();
    pop_chk(active); pop_chk(by(0));
    hit = '0;
    stop = 0;
    move_tick = 0;
    clear = 1;
    push("cl_act", 0); push("cl_free", 6); push("cl_y1", 1000);
    tick();
    pop_chk(active); pop_chk(free_count); pop_chk(by(1));
    clear = 0;

    // asynchronous reset mid-game, then first spawn goes to slot 0
    idle(GAP);
    fire = 1;
    tick();
    fire = 0;
    idle(GAP);
    fire = 1;
    tick();
    fire = 0;
    #3;
    reset_n = 1'b0;
    #1;
    push("mr_act", 0); push("mr_free", 6);
    push("mr_y1", 1000); push("mr_x0", 0);
    pop_chk(active); pop_chk(free_count);
    pop_chk(by(1)); pop_chk(bx(0));
    tick();
    reset_n = 1'b1;
    tick();
    fire = 1;
    push("pr_act", 1); push("pr_y0", 393);
    tick();
    pop_chk(active); pop_chk(by(0));
    fire = 0;

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_left: observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
